fir_error_monitor: RTL and testbench
====================================

Name: fir_error_monitor

Overview:
- Sits directly downstream of the shift-coefficient FIR filter (filterfir).
- Consumes the approximate-adder FIR output alongside an exact-adder FIR output for the same input stream.
- Accumulates error statistics over a fixed window of samples: sum, maximum and count of nonzero absolute errors, plus mean absolute error.
- Presents the results through a valid/ready handshake, for AxPPA accuracy characterisation.

Parameters:
- DW, 16: sample width of both FIR outputs (unsigned).
- WIN_LOG2, 8: log2 of window length; window N = 2^WIN_LOG2 samples.
- SUMW, DW+WIN_LOG2: width of the absolute-error accumulator; sized so it never overflows.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a new window.
- in_valid  in  1  approx_in/exact_in carry a sample this cycle.
- approx_in  in  DW  approximate FIR output (dataout of filterfir).
- exact_in  in  DW  exact FIR output for the same sample index.
- busy  out  1  high while in ACCUM.
- res_valid  out  1  results valid, held until accepted.
- res_ready  in  1  consumer accepts results.
- sum_abs_err  out  SUMW  sum of |approx-exact| over the window.
- max_abs_err  out  DW  largest |approx-exact| in the window.
- err_count  out  WIN_LOG2+1  number of samples with nonzero error (0..N).
- mean_abs_err  out  DW  sum_abs_err >> WIN_LOG2 (truncating).

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs, accumulators and the sample counter go to 0 immediately. Reset mid-window discards partial results.
- Error arithmetic: both inputs unsigned. diff = approx_in - exact_in if approx_in >= exact_in, else exact_in - approx_in. diff is DW bits, max 2^DW-1; no wrap.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - in_valid ignored; outputs keep their last values (0 after reset).
  - start=1 -> ACCUM next cycle. On that edge, clear sum, max, err_count and sample counter, and drop res_valid to 0.
- ACCUM:
  - Each cycle with in_valid=1, update on the edge:
    - sum += diff
    - max = max(max, diff)
    - err_count += (diff != 0)
    - sample counter += 1
  - in_valid=0: no update. Gaps of any length are allowed.
  - start ignored.
  - When the accepted sample is the Nth (counter == N-1 before increment), go to HOLD on the same edge with final values registered. res_valid=1 and mean_abs_err valid in the cycle after the Nth sample is accepted (latency 1).
- HOLD:
  - res_valid=1; all result outputs stable; in_valid ignored.
  - res_valid & res_ready on an edge completes the handshake.
    - start=0 in the same cycle: -> IDLE, res_valid=0, results remain readable.
    - start=1 in the same cycle: -> ACCUM directly, with accumulators cleared as for IDLE+start.
  - start without res_ready is ignored.
- busy = (state==ACCUM), registered with state.
- mean_abs_err is updated together with sum_abs_err, never combinationally from a partial sum.
- Widths: err_count must represent N (all samples in error), hence WIN_LOG2+1 bits. Sample counter is also WIN_LOG2+1 bits.

Test Plan:
All tests use WIN_LOG2=2 (N=4), DW=16 unless noted.
1. start; 4 samples with approx=exact (10,20,30,40) -> res_valid 1 cycle after 4th; sum=0, max=0, count=0, mean=0.
2. start; pairs (100,103), (50,50), (7,0), (0xFFFF,0) -> sum=65545, max=65535, count=3, mean=16386.
3. Same data as 2 with in_valid high every third cycle, random junk on inputs while in_valid=0 -> identical results; busy high from cycle after start until res_valid.
4. Hold res_ready=0 for 10 cycles after res_valid, driving in_valid=1 and start=1 pulses -> outputs frozen, state stays HOLD; then res_ready=1 -> IDLE, res_valid=0 next cycle.
5. Assert rst asynchronously (mid-cycle) after 2 samples of test 2 -> outputs 0 without waiting for clk. Release, start, feed (5,1)x4 -> sum=16, max=4, count=4, mean=4.
6. In HOLD, assert start and res_ready in the same cycle -> next cycle ACCUM, res_valid=0, sum/max/count=0; next window computes fresh results.
7. DW=16, WIN_LOG2=8: 256 samples of (0xFFFF,0) -> sum=0xFFFF00 with no overflow, count=256, max=0xFFFF, mean=0xFFFF.

Source files
------------

// File: rtl/fir_error_monitor.sv
// fir_error_monitor: windowed error statistics between approximate and exact FIR outputs.
// Accumulates sum, max, nonzero count and mean of |approx - exact| over 2^WIN_LOG2
// accepted samples, then holds the results behind a valid/ready handshake.
module fir_error_monitor #(
    parameter int unsigned DW       = 16,
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned SUMW     = DW + WIN_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DW-1:0]         approx_in,
    input  logic [DW-1:0]         exact_in,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SUMW-1:0]       sum_abs_err,
    output logic [DW-1:0]         max_abs_err,
    output logic [WIN_LOG2:0]     err_count,
    output logic [DW-1:0]         mean_abs_err
);

    localparam int unsigned CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   smp_cnt;
    logic [DW-1:0]   diff_c;
    logic [SUMW-1:0] sum_next_c;

    // Absolute difference of the two unsigned samples, never wraps.
    always_comb begin
        diff_c = '0;
        if (approx_in >= exact_in) begin
            diff_c = approx_in - exact_in;
        end else begin
            diff_c = exact_in - approx_in;
        end
    end

    assign sum_next_c = sum_abs_err + SUMW'(diff_c);

    // Window FSM with registered statistics, handshake and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            err_count    <= '0;
            mean_abs_err <= '0;
            smp_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ACCUM;
                        busy         <= 1'b1;
                        res_valid    <= 1'b0;
                        sum_abs_err  <= '0;
                        max_abs_err  <= '0;
                        err_count    <= '0;
                        mean_abs_err <= '0;
                        smp_cnt      <= '0;
                    end
                end

                ACCUM: begin
                    if (in_valid) begin
                        sum_abs_err  <= sum_next_c;
                        mean_abs_err <= DW'(sum_next_c >> WIN_LOG2);
                        if (diff_c > max_abs_err) begin
                            max_abs_err <= diff_c;
                        end
                        if (diff_c != '0) begin
                            err_count <= err_count + CW'(1);
                        end
                        smp_cnt <= smp_cnt + CW'(1);
                        if (smp_cnt == LAST_IDX) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back window: skip IDLE and clear as on a fresh start.
                            state        <= ACCUM;
                            busy         <= 1'b1;
                            sum_abs_err  <= '0;
                            max_abs_err  <= '0;
                            err_count    <= '0;
                            mean_abs_err <= '0;
                            smp_cnt      <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_error_monitor.sv
// Self-checking bench for fir_error_monitor: vector table, corner-case sequences,
// randomized windows against a plain-arithmetic reference model, and a full-size window.
module tb_fir_error_monitor;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Small instance, N = 4
    logic          start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic [15:0]   approx_in = '0, exact_in = '0;
    logic          busy, res_valid;
    logic [17:0]   sum_abs_err;
    logic [15:0]   max_abs_err, mean_abs_err;
    logic [2:0]    err_count;

    // Full-size instance, N = 256
    logic          b_start = 1'b0, b_in_valid = 1'b0, b_res_ready = 1'b0;
    logic [15:0]   b_approx = '0, b_exact = '0;
    logic          b_busy, b_res_valid;
    logic [23:0]   b_sum;
    logic [15:0]   b_max, b_mean;
    logic [8:0]    b_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_error_monitor #(.DW(DW), .WIN_LOG2(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .approx_in(approx_in), .exact_in(exact_in), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err), .err_count(err_count), .mean_abs_err(mean_abs_err)
    );

    fir_error_monitor #(.DW(DW), .WIN_LOG2(8)) dut_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid),
        .approx_in(b_approx), .exact_in(b_exact), .busy(b_busy),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .sum_abs_err(b_sum),
        .max_abs_err(b_max), .err_count(b_count), .mean_abs_err(b_mean)
    );

    typedef struct packed {
        logic [3:0][15:0] a;
        logic [3:0][15:0] e;
        logic [1:0]       gap;
        logic [17:0]      sum;
        logic [15:0]      mx;
        logic [2:0]       cnt;
        logic [15:0]      mean;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse start for one cycle; caller is at a negedge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("res_valid_after_start", res_valid, 0);
    endtask

    // Feed four samples with 'gap' junk cycles before each.
    task automatic feed(input logic [3:0][15:0] a, input logic [3:0][15:0] e, input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                in_valid  = 1'b0;
                approx_in = 16'($urandom);
                exact_in  = 16'($urandom);
                @(negedge clk);
                check("busy_gap", busy, 1);
            end
            in_valid  = 1'b1;
            approx_in = a[i];
            exact_in  = e[i];
            @(negedge clk);
            if (i < 3) check("busy_mid", busy, 1);
        end
        in_valid  = 1'b0;
        approx_in = 16'($urandom);
        exact_in  = 16'($urandom);
    endtask

    task automatic check_results(input string tag, input longint s, input longint m,
                                 input longint c, input longint mn);
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sum"}, sum_abs_err, s);
        check({tag, "_max"}, max_abs_err, m);
        check({tag, "_count"}, err_count, c);
        check({tag, "_mean"}, mean_abs_err, mn);
    endtask

    task automatic ack(input int delay);
        repeat (delay) begin
            @(negedge clk);
            check("res_valid_hold", res_valid, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_after_ack", res_valid, 0);
        check("busy_after_ack", busy, 0);
    endtask

    // Reference: statistics straight from the definition of |approx - exact|.
    task automatic model(input logic [3:0][15:0] a, input logic [3:0][15:0] e,
                         output longint s, output longint m, output longint c, output longint mn);
        int d;
        s = 0; m = 0; c = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(a[i]) - int'(e[i]);
            if (d < 0) d = -d;
            s += d;
            if (d > m) m = d;
            if (d != 0) c++;
        end
        mn = s / 4;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        longint s, m, c, mn;
        logic [3:0][15:0] ra, re;
        logic [15:0] f_sum, f_max, f_mean;
        logic [2:0]  f_cnt;

        vecs[0] = '{a: {16'd40, 16'd30, 16'd20, 16'd10}, e: {16'd40, 16'd30, 16'd20, 16'd10},
                    gap: 2'd0, sum: 18'd0, mx: 16'd0, cnt: 3'd0, mean: 16'd0};
        vecs[1] = '{a: {16'hFFFF, 16'd7, 16'd50, 16'd100}, e: {16'd0, 16'd0, 16'd50, 16'd103},
                    gap: 2'd0, sum: 18'd65545, mx: 16'd65535, cnt: 3'd3, mean: 16'd16386};
        vecs[2] = vecs[1];
        vecs[2].gap = 2'd2;
        vecs[3] = '{a: {16'd5, 16'd5, 16'd5, 16'd5}, e: {16'd1, 16'd1, 16'd1, 16'd1},
                    gap: 2'd1, sum: 18'd16, mx: 16'd4, cnt: 3'd4, mean: 16'd4};
        vecs[4] = '{a: {16'd0, 16'd0, 16'd0, 16'd0}, e: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    gap: 2'd0, sum: 18'd262140, mx: 16'd65535, cnt: 3'd4, mean: 16'd65535};

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sum", sum_abs_err, 0);
        check("rst_count", err_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // IDLE ignores in_valid
        in_valid = 1'b1; approx_in = 16'd9; exact_in = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ignore_sum", sum_abs_err, 0);
        check("idle_ignore_busy", busy, 0);

        // Vector table
        for (int v = 0; v < 5; v++) begin
            do_start();
            feed(vecs[v].a, vecs[v].e, int'(vecs[v].gap));
            check_results($sformatf("vec%0d", v), vecs[v].sum, vecs[v].mx, vecs[v].cnt, vecs[v].mean);
            ack(v % 2);
            check("results_readable_idle", sum_abs_err, vecs[v].sum);
        end

        // Stalled consumer: outputs frozen, start/in_valid ignored in HOLD
        do_start();
        feed(vecs[1].a, vecs[1].e, 0);
        check_results("stall", 65545, 65535, 3, 16386);
        f_sum = 16'(sum_abs_err); f_max = max_abs_err; f_mean = mean_abs_err; f_cnt = err_count;
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            approx_in = 16'($urandom);
            exact_in  = 16'($urandom);
            start     = (k % 3 == 0);
            @(negedge clk);
            check("stall_valid", res_valid, 1);
            check("stall_busy", busy, 0);
            check("stall_sum", sum_abs_err, 65545);
            check("stall_frozen", {max_abs_err, mean_abs_err, err_count}, {f_max, f_mean, f_cnt});
        end
        start = 1'b0; in_valid = 1'b0;
        ack(0);
        check("stall_sum_after", 16'(sum_abs_err), f_sum);

        // Asynchronous reset mid-window
        do_start();
        in_valid = 1'b1; approx_in = 16'd100; exact_in = 16'd103;
        @(negedge clk);
        approx_in = 16'd50; exact_in = 16'd50;
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_sum", sum_abs_err, 3);
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", res_valid, 0);
        check("async_sum", sum_abs_err, 0);
        check("async_max", max_abs_err, 0);
        check("async_count", err_count, 0);
        check("async_mean", mean_abs_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        feed(vecs[3].a, vecs[3].e, 0);
        check_results("after_rst", 16, 4, 4, 4);

        // Ack with start in the same cycle: straight back into ACCUM
        start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", res_valid, 0);
        check("b2b_sum", sum_abs_err, 0);
        check("b2b_max", max_abs_err, 0);
        check("b2b_count", err_count, 0);
        feed(vecs[1].a, vecs[1].e, 1);
        check_results("b2b", 65545, 65535, 3, 16386);
        ack(0);

        // Randomized windows against the reference model
        for (int w = 0; w < 30; w++) begin
            for (int i = 0; i < 4; i++) begin
                re[i] = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       ra[i] = re[i];
                    1:       ra[i] = re[i] + 16'($urandom_range(0, 7));
                    2:       ra[i] = re[i] - 16'($urandom_range(0, 7));
                    default: ra[i] = 16'($urandom);
                endcase
            end
            model(ra, re, s, m, c, mn);
            do_start();
            feed(ra, re, int'($urandom_range(0, 2)));
            check_results($sformatf("rnd%0d", w), s, m, c, mn);
            ack(int'($urandom_range(0, 3)));
        end

        // Full-size window: 256 maximal errors, no accumulator overflow
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check("big_busy", b_busy, 1);
        for (int i = 0; i < 256; i++) begin
            b_in_valid = 1'b1; b_approx = 16'hFFFF; b_exact = 16'h0000;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check("big_valid", b_res_valid, 1);
        check("big_sum", b_sum, 24'hFFFF00);
        check("big_count", b_count, 256);
        check("big_max", b_max, 16'hFFFF);
        check("big_mean", b_mean, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
